// File: rtl/ddr_rd_pkg.sv
// Shared definitions for the DDR read scheduler: FSM encodings, boundary default
// and a ceil-log2 helper used to size address offsets.
package ddr_rd_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CALC  = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  localparam int BOUNDARY_DEF = 4096;

  function automatic int clogb2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ddr_rd_burst_calc.sv
// Burst length for the next read: the smallest of the beats still owed, the
// burst cap, and the beats left before the next line boundary.
module ddr_rd_burst_calc
  import ddr_rd_pkg::*;
#(
  parameter int BEATS_W   = 16,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 64,
  parameter int BOUNDARY  = BOUNDARY_DEF,
  parameter int OFF_W     = clogb2(BOUNDARY)
) (
  input  logic [OFF_W-1:0]   line_off,
  input  logic [BEATS_W-1:0] remaining,
  output logic [8:0]         blen
);

  localparam int BPB     = DATA_W / 8;
  localparam int LOG_BPB = clogb2(BPB);
  localparam int CMP_W0  = (BEATS_W > OFF_W + 1) ? BEATS_W : OFF_W + 1;
  localparam int CMP_W   = (CMP_W0 > 10) ? CMP_W0 : 10;

  logic [OFF_W:0]   to_bnd_bytes;
  logic [CMP_W-1:0] to_bnd_beats;
  logic [CMP_W-1:0] rem_w;
  logic [8:0]       lim;

  always_comb begin
    to_bnd_bytes = (OFF_W + 1)'(BOUNDARY) - {1'b0, line_off};
    to_bnd_beats = CMP_W'(to_bnd_bytes >> LOG_BPB);
    rem_w        = CMP_W'(remaining);
    lim          = (to_bnd_beats < CMP_W'(MAX_BURST)) ? to_bnd_beats[8:0] : 9'(MAX_BURST);
    blen         = (rem_w < CMP_W'(lim)) ? rem_w[8:0] : lim;
  end

endmodule

// File: rtl/ddr_rd_sched.sv
// Two-client read scheduler: round-robin per transfer, splits transfers into
// boundary-safe bursts for the single-burst reader and steers beats back.
module ddr_rd_sched
  import ddr_rd_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BEATS_W   = 16,
  parameter int MAX_BURST = 64,
  parameter int BOUNDARY  = BOUNDARY_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*ADDR_W-1:0]  req_addr,
  input  logic [2*BEATS_W-1:0] req_beats,
  output logic [1:0]           xfer_done,
  output logic                 sched_busy,
  output logic                 out_vld,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_id,
  output logic                 out_last,
  output logic                 rd_start,
  output logic [ADDR_W-1:0]    rd_addr,
  output logic [7:0]           rd_len,
  input  logic                 rd_busy,
  input  logic                 rd_done,
  input  logic                 rd_vld,
  input  logic [DATA_W-1:0]    rd_data
);

  localparam int BPB     = DATA_W / 8;
  localparam int LOG_BPB = clogb2(BPB);
  localparam int OFF_W   = clogb2(BOUNDARY);

  logic [1:0]         state_q;
  logic               owner_q;
  logic               last_grant_q;
  logic [BEATS_W-1:0] beat_left_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [BEATS_W-1:0] rem_q;
  logic [8:0]         blen_q;
  logic [ADDR_W-1:0]  rd_addr_q;
  logic [7:0]         rd_len_q;
  logic [1:0]         xfer_done_q;

  logic [1:0]         win;
  logic               acc;
  logic               acc_id;
  logic [ADDR_W-1:0]  sel_addr;
  logic [BEATS_W-1:0] sel_beats;
  logic [BEATS_W-1:0] rem_next;
  logic [8:0]         blen_c;

  // Arbiter: a lone requester wins, a tie goes to the client not served last.
  always_comb begin
    win = 2'b00;
    if (rst_n && state_q == ST_IDLE) begin
      case (req_valid)
        2'b01:   win = 2'b01;
        2'b10:   win = 2'b10;
        2'b11:   win = last_grant_q ? 2'b01 : 2'b10;
        default: win = 2'b00;
      endcase
    end
  end

  always_comb begin
    acc       = |win;
    acc_id    = win[1];
    sel_addr  = (acc_id ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0])
                & ~ADDR_W'(BPB - 1);
    sel_beats = acc_id ? req_beats[2*BEATS_W-1:BEATS_W] : req_beats[BEATS_W-1:0];
    rem_next  = rem_q - BEATS_W'(blen_q);
  end

  ddr_rd_burst_calc #(
    .BEATS_W   (BEATS_W),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST),
    .BOUNDARY  (BOUNDARY),
    .OFF_W     (OFF_W)
  ) u_calc (
    .line_off  (addr_q[OFF_W-1:0]),
    .remaining (rem_q),
    .blen      (blen_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      beat_left_q  <= '0;
      rd_addr_q    <= '0;
      rd_len_q     <= '0;
      xfer_done_q  <= 2'b00;
    end else begin
      xfer_done_q <= 2'b00;
      if (state_q == ST_WAIT && rd_vld && beat_left_q != '0)
        beat_left_q <= beat_left_q - 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (acc) begin
            owner_q      <= acc_id;
            last_grant_q <= acc_id;
            beat_left_q  <= sel_beats;
            if (sel_beats == '0) xfer_done_q <= win;
            else                 state_q     <= ST_CALC;
          end
        end
        ST_CALC: begin
          rd_addr_q <= addr_q;
          rd_len_q  <= blen_c[7:0];
          state_q   <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (!rd_busy) state_q <= ST_WAIT;
        end
        default: begin
          if (rd_done) begin
            if (rem_next == '0) begin
              xfer_done_q <= owner_q ? 2'b10 : 2'b01;
              state_q     <= ST_IDLE;
            end else begin
              state_q <= ST_CALC;
            end
          end
        end
      endcase
    end
  end

  // Transfer cursor: loaded on accept, advanced by the burst just completed.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && acc) begin
      addr_q <= sel_addr;
      rem_q  <= sel_beats;
    end else if (state_q == ST_CALC) begin
      blen_q <= blen_c;
    end else if (state_q == ST_WAIT && rd_done) begin
      addr_q <= addr_q + (ADDR_W'(blen_q) << LOG_BPB);
      rem_q  <= rem_next;
    end
  end

  always_comb begin
    req_ready  = win;
    xfer_done  = xfer_done_q;
    sched_busy = (state_q != ST_IDLE);
    rd_start   = (state_q == ST_ISSUE) && !rd_busy;
    rd_addr    = rd_addr_q;
    rd_len     = rd_len_q;
    out_vld    = (state_q == ST_WAIT) && rd_vld;
    out_data   = rd_data;
    out_id     = owner_q;
    out_last   = out_vld && (beat_left_q == BEATS_W'(1));
  end

endmodule

// File: tb/tb_ddr_rd_sched.sv
// Directed bench for ddr_rd_sched: a 64-beat-cap instance for the main flows
// and a 256-beat-cap instance for the rd_len wrap encoding.
module tb_ddr_rd_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_addr;
  logic [31:0] req_beats;
  logic [1:0]  xfer_done;
  logic        sched_busy, out_vld, out_id, out_last, rd_start;
  logic [31:0] out_data, rd_addr, rd_data;
  logic [7:0]  rd_len;
  logic        rd_busy, rd_done, rd_vld;

  logic [1:0]  b_req_valid, b_req_ready, b_xfer_done;
  logic [63:0] b_req_addr;
  logic [31:0] b_req_beats;
  logic        b_sched_busy, b_out_vld, b_out_id, b_out_last, b_rd_start;
  logic [31:0] b_out_data, b_rd_addr, b_rd_data;
  logic [7:0]  b_rd_len;
  logic        b_rd_busy, b_rd_done, b_rd_vld;

  int ncmp = 0;
  int nerr = 0;
  int left;

  always #5 clk = ~clk;

  ddr_rd_sched dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_beats(req_beats), .xfer_done(xfer_done),
    .sched_busy(sched_busy), .out_vld(out_vld), .out_data(out_data),
    .out_id(out_id), .out_last(out_last), .rd_start(rd_start),
    .rd_addr(rd_addr), .rd_len(rd_len), .rd_busy(rd_busy),
    .rd_done(rd_done), .rd_vld(rd_vld), .rd_data(rd_data)
  );

  ddr_rd_sched #(.MAX_BURST(256)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_addr(b_req_addr), .req_beats(b_req_beats), .xfer_done(b_xfer_done),
    .sched_busy(b_sched_busy), .out_vld(b_out_vld), .out_data(b_out_data),
    .out_id(b_out_id), .out_last(b_out_last), .rd_start(b_rd_start),
    .rd_addr(b_rd_addr), .rd_len(b_rd_len), .rd_busy(b_rd_busy),
    .rd_done(b_rd_done), .rd_vld(b_rd_vld), .rd_data(b_rd_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic request(input int client, input logic [31:0] addr, input logic [15:0] beats);
    req_valid[client]           = 1'b1;
    req_addr[client*32 +: 32]   = addr;
    req_beats[client*16 +: 16]  = beats;
    #1;
    chk("req_ready", req_ready, (client == 1) ? 2'b10 : 2'b01);
    tick;
    req_valid[client] = 1'b0;
  endtask

  // Waits for rd_start, checks the burst, then plays the reader for exp_len beats.
  task automatic serve(input logic [31:0] exp_addr, input int exp_len, input logic id,
                       inout int beats_left, input bit final_burst, input int exp_wait);
    int w;
    w = 0;
    while (rd_start !== 1'b1 && w < 50) begin
      tick;
      w++;
    end
    chk("rd_start_seen", rd_start, 1'b1);
    if (exp_wait >= 0) chk("rd_start_latency", w, exp_wait);
    chk("rd_addr", rd_addr, exp_addr);
    chk("rd_len", rd_len, exp_len[7:0]);
    tick;
    chk("rd_start_single", rd_start, 1'b0);
    for (int k = 0; k < exp_len; k++) begin
      rd_vld  = 1'b1;
      rd_data = 32'hA500_0000 + k;
      rd_done = (k == exp_len - 1);
      #1;
      chk("out_vld", out_vld, 1'b1);
      chk("out_id", out_id, id);
      chk("out_last", out_last, beats_left == 1);
      chk("out_data", out_data, 32'hA500_0000 + k);
      beats_left--;
      tick;
    end
    rd_vld  = 1'b0;
    rd_done = 1'b0;
    rd_data = '0;
    chk("xfer_done", xfer_done, final_burst ? (id ? 2'b10 : 2'b01) : 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog sched_busy=%0b expected run to finish", sched_busy);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_addr = '0; req_beats = '0;
    rd_busy = 1'b0; rd_done = 1'b0; rd_vld = 1'b0; rd_data = '0;
    b_req_valid = '0; b_req_addr = '0; b_req_beats = '0;
    b_rd_busy = 1'b0; b_rd_done = 1'b0; b_rd_vld = 1'b0; b_rd_data = '0;
    repeat (3) tick;
    chk("rst_xfer_done", xfer_done, 2'b00);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_busy", sched_busy, 1'b0);
    chk("rst_rd_start", rd_start, 1'b0);
    chk("rst_rd_addr", rd_addr, 32'h0);
    chk("rst_rd_len", rd_len, 8'h0);
    chk("rst_out", {out_vld, out_id, out_last}, 3'b000);
    rst_n = 1'b1;
    tick;

    // Single 16-beat burst from client 0
    request(0, 32'h0000_0000, 16'd16);
    chk("calc_busy", sched_busy, 1'b1);
    chk("calc_no_start", rd_start, 1'b0);
    left = 16;
    serve(32'h0000_0000, 16, 1'b0, left, 1'b1, 1);
    chk("idle_after_1", sched_busy, 1'b0);

    // Crossing 4 KB: split at 0x1000
    request(0, 32'h0000_0FC0, 16'd64);
    left = 64;
    serve(32'h0000_0FC0, 16, 1'b0, left, 1'b0, 1);
    serve(32'h0000_1000, 48, 1'b0, left, 1'b1, 1);

    // 200 beats capped at 64 per burst, client 1
    request(1, 32'h0000_2000, 16'd200);
    left = 200;
    serve(32'h0000_2000, 64, 1'b1, left, 1'b0, 1);
    serve(32'h0000_2100, 64, 1'b1, left, 1'b0, 1);
    serve(32'h0000_2200, 64, 1'b1, left, 1'b0, 1);
    serve(32'h0000_2300, 8,  1'b1, left, 1'b1, 1);

    // Round-robin with both clients requesting (last grant was client 1)
    req_addr  = {32'h0000_0200, 32'h0000_0100};
    req_beats = {16'd4, 16'd4};
    req_valid = 2'b11;
    #1; chk("rr_grant0", req_ready, 2'b01);
    tick; req_valid[0] = 1'b0;
    left = 4; serve(32'h0000_0100, 4, 1'b0, left, 1'b1, 1);
    req_valid[0] = 1'b1;
    #1; chk("rr_grant1", req_ready, 2'b10);
    tick; req_valid[1] = 1'b0;
    left = 4; serve(32'h0000_0200, 4, 1'b1, left, 1'b1, 1);
    req_valid[1] = 1'b1;
    #1; chk("rr_grant2", req_ready, 2'b01);
    tick; req_valid[0] = 1'b0;
    left = 4; serve(32'h0000_0100, 4, 1'b0, left, 1'b1, 1);
    #1; chk("rr_grant3", req_ready, 2'b10);
    tick; req_valid[1] = 1'b0;
    left = 4; serve(32'h0000_0200, 4, 1'b1, left, 1'b1, 1);

    // Empty transfer: done pulse next cycle, no burst
    request(0, 32'h0000_0300, 16'd0);
    chk("empty_done", xfer_done, 2'b01);
    chk("empty_idle", sched_busy, 1'b0);
    chk("empty_no_start", rd_start, 1'b0);
    tick;
    chk("empty_done_clear", xfer_done, 2'b00);
    chk("empty_still_idle", sched_busy, 1'b0);
    rd_vld = 1'b1;
    #1; chk("idle_vld_ignored", out_vld, 1'b0);
    rd_vld = 1'b0;

    // 256-beat cap instance: short burst then a full 256-beat burst (len 0)
    b_req_addr = 32'h0000_0040; b_req_beats = 32'd2; b_req_valid = 2'b01;
    tick; b_req_valid = 2'b00;
    tick;
    chk("b_start_short", b_rd_start, 1'b1);
    chk("b_len_short", b_rd_len, 8'd2);
    tick;
    b_rd_vld = 1'b1; tick;
    b_rd_done = 1'b1; tick;
    b_rd_vld = 1'b0; b_rd_done = 1'b0;
    chk("b_done_short", b_xfer_done, 2'b01);
    b_req_addr = 32'h0; b_req_beats = 32'd256; b_req_valid = 2'b01;
    tick; b_req_valid = 2'b00;
    tick;
    chk("b_start_256", b_rd_start, 1'b1);
    chk("b_addr_256", b_rd_addr, 32'h0);
    chk("b_len_256", b_rd_len, 8'd0);

    // Reader busy stalls ISSUE, then a reset in WAIT aborts
    rd_busy = 1'b1;
    request(1, 32'h0000_4000, 16'd8);
    for (int i = 0; i < 6; i++) begin
      chk("busy_no_start", rd_start, 1'b0);
      tick;
    end
    rd_busy = 1'b0;
    #1;
    chk("busy_start", rd_start, 1'b1);
    chk("busy_len", rd_len, 8'd8);
    chk("busy_addr", rd_addr, 32'h0000_4000);
    tick;
    chk("busy_single", rd_start, 1'b0);
    for (int k = 0; k < 3; k++) begin
      rd_vld = 1'b1; rd_data = 32'h5A00_0000 + k;
      #1; chk("abort_beat_id", {out_vld, out_id}, 2'b11);
      tick;
    end
    rd_vld = 1'b0; rd_data = '0;
    rst_n = 1'b0;
    tick;
    chk("abort_busy", sched_busy, 1'b0);
    chk("abort_outs", {out_vld, out_id, out_last, rd_start}, 4'b0000);
    chk("abort_rd_addr", rd_addr, 32'h0);
    chk("abort_rd_len", rd_len, 8'h0);
    chk("abort_done", xfer_done, 2'b00);
    rst_n = 1'b1;
    tick;
    chk("abort_no_done", xfer_done, 2'b00);
    req_addr  = {32'h0000_0600, 32'h0000_0500};
    req_beats = {16'd4, 16'd4};
    req_valid = 2'b11;
    #1; chk("post_rst_tie", req_ready, 2'b01);
    tick; req_valid = 2'b00;
    left = 4; serve(32'h0000_0500, 4, 1'b0, left, 1'b1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
